word_serializer: RTL
====================

Name: word_serializer

Overview:
- Parallel-to-serial front end for the serial-bit FSM stages: accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock.
- Sits directly upstream of the bit-stream classifiers (e.g. divisible-by-4 detector); ser_bit drives their "in".
- ser_first is a per-word restart strobe for downstream stages. ser_last marks the bit on which the downstream verdict is valid.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, 16, width of the words_done counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word; sampled only on an accept.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_bit  output  1  current serial bit, MSB first.
- ser_valid  output  1  ser_bit is meaningful this cycle.
- ser_first  output  1  high with the MSB of each word.
- ser_last  output  1  high with the LSB of each word.
- busy  output  1  a word is being shifted out.
- words_done  output  CNT_W  count of fully emitted words; wraps.

Behaviour:
- Reset: rst=1 at a clock edge forces the following registered values.
  - State IDLE.
  - Shift register and bit counter cleared.
  - ser_bit, ser_valid, ser_first, ser_last, busy all 0.
  - words_done = 0.
- Reset overrides every other event in the same cycle.
- Accept: occurs on any edge with in_valid=1 and in_ready=1. in_data is latched in full, and later changes have no effect.
- Outputs are registered. The MSB appears with ser_valid=1 and ser_first=1 on the cycle after the accept (latency 1).
- States:
  - IDLE: in_ready=1, ser_valid=0, busy=0.
    - Accept goes to SHIFT.
    - No accept stays in IDLE.
  - SHIFT: one bit per cycle, MSB..LSB, WIDTH cycles total; busy=1, ser_valid=1.
    - ser_first=1 only on bit WIDTH-1.
    - ser_last=1 only on bit 0.
  - SHIFT exit, without SER_GAP_EN: in_ready=1 only during the ser_last cycle.
    - Accept on that cycle: next cycle shows the new word's MSB with ser_first=1, no bubble, state stays SHIFT.
    - No accept: go to IDLE; ser_valid=0 on the next cycle.
- in_ready is combinational from state/counter only, never from in_valid.
- ser_bit holds its last value while ser_valid=0. Downstream must qualify with ser_valid.
- words_done increments by 1 on each edge that completes a ser_last cycle. Wraps 2^CNT_W-1 -> 0.
- Reset mid-word: the partial word is dropped, no further bits are emitted, and words_done does not increment.
- in_valid held high with in_ready=0: no accept, no data loss upstream; the word waits.

Optional Feature:
- Macro: SER_GAP_EN.
- Defined: adds state GAP, entered after every ser_last cycle.
  - GAP lasts exactly 1 cycle with ser_valid=0, busy=0, in_ready=1.
  - In-ready during the ser_last cycle is 0.
  - An accept in GAP produces the MSB on the next cycle. Otherwise the block goes to IDLE.
  - Sustained throughput is WIDTH bits per WIDTH+1 cycles.
  - Gives downstream FSMs a guaranteed idle cycle to apply a restart.
- Undefined: no GAP state; back-to-back as described in Behaviour.

Test Plan:
- Reset, then idle for 5 cycles: in_ready=1, ser_valid=0, busy=0, words_done=0 throughout.
- WIDTH=8, accept 0xA4: the next 8 cycles emit ser_bit 1,0,1,0,0,1,0,0 with ser_valid=1.
  - ser_first on cycle 1 and ser_last on cycle 8.
  - The downstream divisible-by-4 FSM flags on the cycle after ser_last. words_done=1.
- Back-to-back 0x03 then 0xFC with in_valid held high (no SER_GAP_EN):
  - 16 consecutive valid bits 00000011 11111100, second ser_first immediately after the first ser_last.
  - words_done=2.
- Same stimulus with SER_GAP_EN: exactly one cycle of ser_valid=0 between the two words, then 11111100.
- Assert rst during bit 4 of 0xFF: the next cycle has ser_valid=0, busy=0, in_ready=1, and words_done is unchanged at 0.
- CNT_W=2, send 5 words: words_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end for the bit-stream FSM stages.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it MSB-first,
// one bit per clk, with first/last strobes and a wrapping completed-word count.
//
// Optional build macro: SER_GAP_EN
//   undefined : back-to-back words with no bubble (in_ready high on the last bit)
//   defined   : one GAP cycle after every word, ready only in IDLE/GAP
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word in flight; in_ready=1, ser_valid=0
// SHIFT | emitting bits WIDTH-1..0, one per cycle; busy=1, ser_valid=1
// GAP   | (SER_GAP_EN only) one idle cycle after a word; in_ready=1
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    cnt;
    logic             last_bit;
    logic             accept;

    // cnt is a down-counter of bits still to emit after the current one
    assign last_bit = (state == SHIFT) && (cnt == '0);

    // Ready depends on state/counter only, never on in_valid
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
`ifdef SER_GAP_EN
            SHIFT:   in_ready = 1'b0;
            GAP:     in_ready = 1'b1;
`else
            SHIFT:   in_ready = last_bit;
            GAP:     in_ready = 1'b0;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Main sequencer: load on accept, shift otherwise, strobes registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            // MSB goes out directly; the register keeps the remaining bits
            state     <= SHIFT;
            ser_bit   <= in_data[WIDTH-1];
            shreg     <= {in_data[WIDTH-2:0], 1'b0};
            cnt       <= BW'(WIDTH - 1);
            ser_valid <= 1'b1;
            ser_first <= 1'b1;
            ser_last  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        ser_bit   <= shreg[WIDTH-1];
                        shreg     <= {shreg[WIDTH-2:0], 1'b0};
                        cnt       <= cnt - 1'b1;
                        ser_first <= 1'b0;
                        ser_last  <= (cnt == BW'(1));
                    end else begin
`ifdef SER_GAP_EN
                        state <= GAP;
`else
                        state <= IDLE;
`endif
                        ser_valid <= 1'b0;
                        ser_first <= 1'b0;
                        ser_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completed-word counter: bumps on the edge that ends each ser_last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            words_done <= '0;
        end else if (last_bit) begin
            words_done <= words_done + 1'b1;
        end
    end

endmodule
